// File: rtl/carousel_pkg.sv
// Shared types for the carousel join stage.
//   join_state_t  : lane-occupancy state of the join FSM
//   BEAT_COUNT_W  : width of the emitted-beat counter
//   occupancy_state() : maps "any lane non-empty" / "all lanes non-empty" to a state
package carousel_pkg;

    localparam int BEAT_COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        READY  = 2'd2
    } join_state_t;

    function automatic join_state_t occupancy_state(input logic any_ne, input logic all_ne);
        if (all_ne)
            return READY;
        else if (any_ne)
            return GATHER;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Small per-lane FIFO for the carousel join stage.
//   clk, rst      : clock, asynchronous active-low reset
//   push, wdata   : write strobe/data (ignored while full)
//   pop, rdata    : read strobe (ignored while empty), head-of-queue data
//   full, empty   : occupancy flags from the registered count
//   count         : number of stored words
module lane_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [AW-1:0]                    wr_ptr;
    logic [AW-1:0]                    rd_ptr;
    logic                             do_push;
    logic                             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: a reset empties the FIFO, so stale words are never read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/carousel_lane_join.sv
// Carousel join stage: buffers NUM_LANES valid/ready lanes and emits one joined
// beat (lane i at [i*DATA_WIDTH +: DATA_WIDTH]) once every lane holds a word.
//   clk, rst                    : clock, asynchronous active-low reset
//   data_in/_valid/_ready       : per-lane input handshakes
//   data_out/_valid, data_out_ready : joined output beat
//   beat_count                  : beats accepted downstream (wrapping)
//   skew_err, err_clear         : sticky lane-skew error and its synchronous clear
module carousel_lane_join
    import carousel_pkg::*;
#(
    parameter int NUM_LANES  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2,
    parameter int MAX_SKEW   = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_LANES-1:0]            data_in_valid,
    output logic [NUM_LANES-1:0]            data_in_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic [BEAT_COUNT_W-1:0]         beat_count,
    output logic                            skew_err,
    input  logic                            err_clear
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(MAX_SKEW+1);

    logic [NUM_LANES-1:0]                 lane_full;
    logic [NUM_LANES-1:0]                 lane_empty;
    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_head;
    logic [NUM_LANES-1:0][CW-1:0]         unused_lane_cnt;
    logic                                 all_ne;
    logic                                 any_ne;
    logic                                 fire;
    join_state_t                          state;
    join_state_t                          state_nxt;
    logic [SW-1:0]                        skew_cnt;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (data_in_valid[i] & data_in_ready[i]),
            .wdata (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .pop   (fire),
            .rdata (lane_head[i]),
            .full  (lane_full[i]),
            .empty (lane_empty[i]),
            .count (unused_lane_cnt[i])
        );
    end

    // Ready comes straight from the registered fill level; a same-cycle pop
    // does not open the lane, which keeps ready free of output-side paths.
    assign data_in_ready = ~lane_full;

    assign all_ne = &(~lane_empty);
    assign any_ne = |(~lane_empty);
    assign fire   = all_ne & (~data_out_valid | data_out_ready);

    // Join FSM: state tracks lane occupancy as seen one cycle earlier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = occupancy_state(any_ne, all_ne);
    end

    // Skew counter only runs while a partial set is waiting; it saturates so the
    // error condition stays asserted until the set completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skew_cnt <= '0;
        end else if (fire || state != GATHER) begin
            skew_cnt <= '0;
        end else if (skew_cnt != SW'(MAX_SKEW)) begin
            skew_cnt <= skew_cnt + SW'(1);
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skew_err <= 1'b0;
        end else if (state == GATHER && skew_cnt == SW'(MAX_SKEW)) begin
            skew_err <= 1'b1;
        end else if (err_clear) begin
            skew_err <= 1'b0;
        end
    end

    // Output register: loads on fire, otherwise holds until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (fire) begin
            data_out       <= lane_head;
            data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_count <= '0;
        end else if (data_out_valid && data_out_ready) begin
            beat_count <= beat_count + BEAT_COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_carousel_lane_join.sv
module tb_carousel_lane_join;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data_in;
    logic [2:0]  data_in_valid;
    logic [2:0]  data_in_ready;
    logic [23:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic [15:0] beat_count;
    logic        skew_err;
    logic        err_clear;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_beats  = 0;
    int          idx[3];
    logic [2:0]  stream_mask = 3'b000;
    logic [23:0] rx_q[$];

    carousel_lane_join #(
        .NUM_LANES  (3),
        .DATA_WIDTH (8),
        .DEPTH      (2),
        .MAX_SKEW   (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .beat_count     (beat_count),
        .skew_err       (skew_err),
        .err_clear      (err_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] w(input int lane, input int k);
        return 8'((lane + 1) * 16 + k);
    endfunction

    task automatic drive_stream();
        data_in_valid = stream_mask;
        for (int i = 0; i < 3; i++) data_in[i*8 +: 8] = w(i, idx[i]);
    endtask

    // One cycle, negedge to negedge: records handshakes that complete at the posedge.
    task automatic tick();
        logic [2:0] acc;
        acc = data_in_valid & data_in_ready;
        if (data_out_valid && data_out_ready) begin
            rx_q.push_back(data_out);
            n_beats++;
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) if (acc[i]) idx[i]++;
        @(negedge clk);
        if (stream_mask != 3'b000) drive_stream();
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        data_in        = '0;
        data_in_valid  = '0;
        data_out_ready = 1'b1;
        err_clear      = 1'b0;
        for (int i = 0; i < 3; i++) idx[i] = 0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", data_out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_beats", beat_count, 0);
        check("rst_err", skew_err, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", data_in_ready, 3'b111);

        // 1: single aligned set
        data_in = 24'h332211; data_in_valid = 3'b111;
        tick(); data_in_valid = 3'b000;
        check("t1_no_early_valid", data_out_valid, 0);
        tick();
        check("t1_valid", data_out_valid, 1);
        check("t1_data", data_out, 24'h332211);
        tick();
        check("t1_beats", beat_count, 1);
        check("t1_valid_drop", data_out_valid, 0);

        // 2: lane 2 arrives 20 cycles late
        data_in = 24'h00BBAA; data_in_valid = 3'b011;
        tick(); data_in_valid = 3'b000;
        repeat (10) tick();
        check("t2_err_not_yet", skew_err, 0);
        repeat (9) tick();
        check("t2_err_set", skew_err, 1);
        check("t2_no_beat_yet", data_out_valid, 0);
        data_in = 24'hCC0000; data_in_valid = 3'b100;
        tick(); data_in_valid = 3'b000;
        tick();
        check("t2_valid", data_out_valid, 1);
        check("t2_data", data_out, 24'hCCBBAA);
        tick();
        check("t2_beats", beat_count, 2);
        check("t2_err_sticky", skew_err, 1);
        err_clear = 1'b1;
        tick(); err_clear = 1'b0;
        check("t2_err_cleared", skew_err, 0);

        // 3: output stalled while lanes stream
        for (int i = 0; i < 3; i++) idx[i] = 0;
        rx_q.delete();
        data_out_ready = 1'b0;
        stream_mask = 3'b111; drive_stream();
        repeat (10) tick();
        for (int i = 0; i < 3; i++) check("t3_accepted", idx[i], 3);
        check("t3_ready_low", data_in_ready, 3'b000);
        check("t3_held_valid", data_out_valid, 1);
        check("t3_held_data", data_out, 24'h302010);
        stream_mask = 3'b000; data_in_valid = 3'b000;
        data_out_ready = 1'b1;
        repeat (6) tick();
        check("t3_nbeats", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("t3_beat0", rx_q[0], 24'h302010);
            check("t3_beat1", rx_q[1], 24'h312111);
            check("t3_beat2", rx_q[2], 24'h322212);
        end
        check("t3_beats", beat_count, 5);

        // 4: full-rate streaming and counter wrap
        stream_mask = 3'b111; drive_stream();
        repeat (4) tick();
        base = n_beats;
        repeat (100) tick();
        check("t4_throughput", n_beats - base, 100);
        rx_q.delete();
        for (int c = 0; c < 70000 && n_beats < 65535; c++) begin
            tick();
            rx_q.delete();
        end
        check("t4_at_ffff", beat_count, 16'hFFFF);
        tick();
        check("t4_wrap", beat_count, 16'h0000);

        // 5: reset with words buffered and a beat pending
        stream_mask = 3'b000; data_in_valid = 3'b000;
        repeat (4) tick();
        check("t5_drained", data_out_valid, 0);
        data_out_ready = 1'b0;
        data_in = 24'h030201; data_in_valid = 3'b111; tick();
        data_in = 24'h060504; tick();
        data_in = 24'h090807; tick();
        data_in_valid = 3'b000;
        check("t5_pre_ready", data_in_ready, 3'b000);
        check("t5_pre_valid", data_out_valid, 1);
        check("t5_pre_data", data_out, 24'h030201);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_valid", data_out_valid, 0);
        check("t5_rst_data", data_out, 0);
        check("t5_rst_beats", beat_count, 0);
        check("t5_rst_ready", data_in_ready, 3'b111);
        n_beats = 0;
        @(negedge clk);
        rst = 1'b1;
        data_out_ready = 1'b1;
        data_in = 24'hC3B2A1; data_in_valid = 3'b111;
        tick(); data_in_valid = 3'b000;
        tick();
        check("t5_post_valid", data_out_valid, 1);
        check("t5_post_data", data_out, 24'hC3B2A1);
        tick();
        check("t5_post_beats", beat_count, 1);

        // 6: lane 0 fills alone, then push and pop coincide on it
        for (int i = 0; i < 3; i++) idx[i] = 0;
        rx_q.delete();
        stream_mask = 3'b001; drive_stream();
        repeat (4) tick();
        check("t6_lane0_words", idx[0], 2);
        check("t6_lane0_full", data_in_ready[0], 0);
        check("t6_no_beat", data_out_valid, 0);
        stream_mask = 3'b111; drive_stream();
        repeat (3) tick();
        repeat (5) begin
            tick();
            check("t6_ready_steady", data_in_ready, 3'b111);
        end
        stream_mask = 3'b000; data_in_valid = 3'b000;
        repeat (5) tick();
        check("t6_lanes_equal", idx[0], idx[1]);
        check("t6_nbeats", rx_q.size(), idx[1]);
        for (int k = 0; k < rx_q.size(); k++)
            check("t6_order", rx_q[k], {w(2, k), w(1, k), w(0, k)});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
